led_dimmer: RTL and testbench
=============================

// Module: led_dimmer
// PURPOSE
//   Output stage directly downstream of the 24-bit LED register: takes its latched
//   ledout pattern and drives the board LED pins. Adds per-group PWM brightness and
//   blink, set through the same memory-mapped write interface (cs/write/addr/data)
//   as the LED register. Three groups: G0=bits[7:0], G1=[15:8], G2=[23:16].
// PARAMETERS
//   PRESCALE       default 64   clocks per PWM step (>=1); 256 steps = one PWM period
//   BLINK_PERIODS  default 256  PWM periods per blink half-phase (>=1)
// PORTS
//   dim_clk    in   1   system clock
//   dimrst     in   1   reset, asynchronous, active-high
//   dimcs      in   1   chip select from the memory/IO decoder
//   dimwrite   in   1   write strobe
//   dimaddr    in   2   register address, low bits
//   dimwdata   in   16  write data (16 data lines only)
//   led_in     in   24  latched LED pattern from the LED register
//   led_pin    out  24  registered drive to board LEDs
//   pwm_wrap   out  1   one-cycle pulse at last clock of each PWM period
// BEHAVIOUR
//   Registers (write when dimcs && dimwrite, on posedge dim_clk):
//     addr 2'b00: pend_duty0 <= dimwdata[7:0]; pend_duty1 <= dimwdata[15:8]
//     addr 2'b10: pend_duty2 <= dimwdata[7:0]; pend_blink[2:0] <= dimwdata[10:8]
//     addr 2'b01/2'b11: no effect. dimwdata[15:11] at 2'b10 ignored. No readback.
//   Shadowing: pend_* copy into active duty/blink regs only on cycle where pwm_wrap=1;
//     a write on that same cycle lands in pend_* and is applied at the NEXT wrap.
//   Prescaler: pre_cnt counts 0..PRESCALE-1, step pulse when pre_cnt==PRESCALE-1.
//   PWM: 8-bit pwm_cnt increments on each step, wraps 255->0. pwm_wrap=1 when
//     step && pwm_cnt==255 (combinational from registered counters).
//   Blink: blk_cnt counts wraps 0..BLINK_PERIODS-1; on wrap at BLINK_PERIODS-1,
//     blk_cnt<=0 and phase toggles. phase=1 means visible.
//   Group gate g_on(k) = (duty_k==8'hFF || pwm_cnt < duty_k) && (!blink_k || phase).
//     duty 0 = always off; 8'hFF = always on (not 255/256).
//   led_pin[i] <= led_in[i] & g_on(group(i)); one-cycle latency from led_in/counters.
//   Reset (async, any time, incl. mid-period): led_pin=0, pwm_wrap=0, pre_cnt=0,
//     pwm_cnt=0, blk_cnt=0, phase=1, pend_duty*=active duty*=8'hFF,
//     pend_blink=active blink=3'b000 (transparent pass-through after reset).
//   After reset release, first led_pin update on first posedge; first pwm_wrap at
//     clock 256*PRESCALE.
// TESTING (bench uses PRESCALE=1, BLINK_PERIODS=2)
//   1. Reset, led_in=24'hA5C3F0 -> led_pin=24'hA5C3F0 from 1st clock, never gaps.
//   2. Assert dimrst mid-run -> led_pin=0 immediately; counters and duties at reset values.
//   3. Write addr 00 data 16'h4000 -> until next wrap unchanged; after wrap G0 dark,
//      G1 on exactly 64 of every 256 clocks (pwm_cnt 0..63), G2 full on.
//   4. Write addr 10 data 16'h0480 -> after wrap G2 duty 128 with blink: on 128/256
//      in phase-1 periods, fully dark for 2 periods, alternating; blink bits 0/1 unaffected.
//   5. Write addr 01 and 11 (any data), and write with dimcs=0 -> no register change.
//   6. Write on the pwm_wrap cycle -> new value takes effect one full period later (256 clks).

Source files
------------

// File: rtl/led_dimmer_if.sv
// Memory-mapped write port shared with the LED register: chip select, strobe,
// address and data driven by the bus master into the dimmer.
interface led_dimmer_if;
    logic        dimcs;
    logic        dimwrite;
    logic [1:0]  dimaddr;
    logic [15:0] dimwdata;

    modport master (
        output dimcs,
        output dimwrite,
        output dimaddr,
        output dimwdata
    );

    modport slave (
        input dimcs,
        input dimwrite,
        input dimaddr,
        input dimwdata
    );
endinterface

// File: rtl/led_dimmer.sv
// LED output stage: gates the latched 24-bit LED pattern per 8-bit group with
// PWM brightness and blink, using shadow registers that update on PWM wrap.
module led_dimmer #(
    parameter int PRESCALE      = 64,
    parameter int BLINK_PERIODS = 256
) (
    input  logic        dim_clk,
    input  logic        dimrst,
    led_dimmer_if.slave bus,
    input  logic [23:0] led_in,
    output logic [23:0] led_pin,
    output logic        pwm_wrap
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_PERIODS - 1);

    logic [PW-1:0] r_pre_cnt;
    logic [7:0]    r_pwm_cnt;
    logic [BW-1:0] r_blk_cnt;
    logic          r_phase;
    logic [7:0]    r_pend_duty0, r_pend_duty1, r_pend_duty2;
    logic [7:0]    r_duty0, r_duty1, r_duty2;
    logic [2:0]    r_pend_blink, r_blink;

    logic          w_step;
    logic          w_wrap;
    logic          w_wr;
    logic [2:0]    w_gate;
    logic          w_unused;

    // Duty 8'hFF is a true always-on, not 255/256 of the period.
    function automatic logic group_on(input logic [7:0] duty, input logic blink,
                                      input logic [7:0] cnt, input logic phase);
        return ((duty == 8'hFF) || (cnt < duty)) && (!blink || phase);
    endfunction

    // Step/wrap decode and per-group gate from registered state.
    always_comb begin
        w_step    = (r_pre_cnt == PRE_LAST);
        w_wrap    = w_step && (r_pwm_cnt == 8'hFF);
        w_wr      = bus.dimcs && bus.dimwrite;
        w_gate[0] = group_on(r_duty0, r_blink[0], r_pwm_cnt, r_phase);
        w_gate[1] = group_on(r_duty1, r_blink[1], r_pwm_cnt, r_phase);
        w_gate[2] = group_on(r_duty2, r_blink[2], r_pwm_cnt, r_phase);
    end

    assign pwm_wrap = w_wrap;
    assign w_unused = ^bus.dimwdata[15:11];

    // Prescaler, PWM counter and blink phase timebase.
    always_ff @(posedge dim_clk or posedge dimrst) begin
        if (dimrst) begin
            r_pre_cnt <= {PW{1'b0}};
            r_pwm_cnt <= 8'd0;
            r_blk_cnt <= {BW{1'b0}};
            r_phase   <= 1'b1;
        end else begin
            if (w_step) begin
                r_pre_cnt <= {PW{1'b0}};
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end else begin
                r_pre_cnt <= r_pre_cnt + PW'(1);
            end
            if (w_wrap) begin
                if (r_blk_cnt == BLK_LAST) begin
                    r_blk_cnt <= {BW{1'b0}};
                    r_phase   <= ~r_phase;
                end else begin
                    r_blk_cnt <= r_blk_cnt + BW'(1);
                end
            end
        end
    end

    // Pending registers take bus writes; actives copy them only at PWM wrap,
    // so a write on the wrap cycle itself waits for the following wrap.
    always_ff @(posedge dim_clk or posedge dimrst) begin
        if (dimrst) begin
            r_pend_duty0 <= 8'hFF;
            r_pend_duty1 <= 8'hFF;
            r_pend_duty2 <= 8'hFF;
            r_pend_blink <= 3'b000;
            r_duty0      <= 8'hFF;
            r_duty1      <= 8'hFF;
            r_duty2      <= 8'hFF;
            r_blink      <= 3'b000;
        end else begin
            if (w_wr) begin
                case (bus.dimaddr)
                    2'b00: begin
                        r_pend_duty0 <= bus.dimwdata[7:0];
                        r_pend_duty1 <= bus.dimwdata[15:8];
                    end
                    2'b10: begin
                        r_pend_duty2 <= bus.dimwdata[7:0];
                        r_pend_blink <= bus.dimwdata[10:8];
                    end
                    default: begin
                    end
                endcase
            end
            if (w_wrap) begin
                r_duty0 <= r_pend_duty0;
                r_duty1 <= r_pend_duty1;
                r_duty2 <= r_pend_duty2;
                r_blink <= r_pend_blink;
            end
        end
    end

    // Registered LED drive.
    always_ff @(posedge dim_clk or posedge dimrst) begin
        if (dimrst) begin
            led_pin <= 24'h000000;
        end else begin
            led_pin <= led_in & {{8{w_gate[2]}}, {8{w_gate[1]}}, {8{w_gate[0]}}};
        end
    end
endmodule

// File: tb/tb_led_dimmer.sv
// Directed bench for led_dimmer with PRESCALE=1, BLINK_PERIODS=2; expected
// pins come from the gate equation applied to the hand-scheduled duty settings.
module tb_led_dimmer;
    logic        dim_clk;
    logic        dimrst;
    logic [23:0] led_in;
    logic [23:0] led_pin;
    logic        pwm_wrap;

    led_dimmer_if bus_if ();

    led_dimmer #(
        .PRESCALE      (1),
        .BLINK_PERIODS (2)
    ) dut (
        .dim_clk  (dim_clk),
        .dimrst   (dimrst),
        .bus      (bus_if.slave),
        .led_in   (led_in),
        .led_pin  (led_pin),
        .pwm_wrap (pwm_wrap)
    );

    int         k;
    int         n_assert;
    int         n_fail;
    logic [7:0] e_d0, e_d1, e_d2;
    logic [2:0] e_bl;

    initial dim_clk = 1'b0;
    always #5 dim_clk = ~dim_clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    function automatic logic gon(input logic [7:0] d, input logic b, input int pwm, input logic ph);
        return ((d == 8'hFF) || (pwm < int'(d))) && (!b || ph);
    endfunction

    // Pins after posedge kk reflect pwm_cnt (kk-1)%256 of period (kk-1)/256;
    // with two periods per blink half-phase, visibility is on in periods 0,1,4,5,...
    function automatic logic [23:0] exp_pins(input int kk);
        int   pwm;
        int   p;
        logic ph, g0, g1, g2;
        pwm = (kk - 1) % 256;
        p   = (kk - 1) / 256;
        ph  = ((p / 2) % 2) == 0;
        g0  = gon(e_d0, e_bl[0], pwm, ph);
        g1  = gon(e_d1, e_bl[1], pwm, ph);
        g2  = gon(e_d2, e_bl[2], pwm, ph);
        return led_in & {{8{g2}}, {8{g1}}, {8{g0}}};
    endfunction

    task automatic tick();
        @(posedge dim_clk);
        k++;
        @(negedge dim_clk);
        chk("led_pin", led_pin, exp_pins(k));
        chk("pwm_wrap", {23'd0, pwm_wrap}, {23'd0, ((k % 256) == 255)});
    endtask

    task automatic run_to(input int kend);
        while (k < kend) tick();
    endtask

    task automatic wr(input logic cs, input logic we, input logic [1:0] addr, input logic [15:0] data);
        bus_if.dimcs    = cs;
        bus_if.dimwrite = we;
        bus_if.dimaddr  = addr;
        bus_if.dimwdata = data;
        tick();
        bus_if.dimcs    = 1'b0;
        bus_if.dimwrite = 1'b0;
        bus_if.dimaddr  = 2'b00;
        bus_if.dimwdata = 16'h0000;
    endtask

    initial begin
        n_assert        = 0;
        n_fail          = 0;
        k               = 0;
        dimrst          = 1'b1;
        led_in          = 24'hA5C3F0;
        bus_if.dimcs    = 1'b0;
        bus_if.dimwrite = 1'b0;
        bus_if.dimaddr  = 2'b00;
        bus_if.dimwdata = 16'h0000;
        e_d0 = 8'hFF; e_d1 = 8'hFF; e_d2 = 8'hFF; e_bl = 3'b000;

        #12;
        chk("reset_led_pin", led_pin, 24'h000000);
        chk("reset_pwm_wrap", {23'd0, pwm_wrap}, 24'h000000);
        @(negedge dim_clk);
        dimrst = 1'b0;

        // Transparent pass-through from the first clock.
        run_to(300);

        // Real write, then writes that must not touch any register.
        wr(1'b1, 1'b1, 2'b00, 16'h4000);
        wr(1'b1, 1'b1, 2'b01, 16'hFFFF);
        wr(1'b1, 1'b1, 2'b11, 16'h0000);
        wr(1'b0, 1'b1, 2'b00, 16'hFFFF);
        wr(1'b1, 1'b0, 2'b00, 16'hFFFF);
        run_to(512);
        e_d0 = 8'h00; e_d1 = 8'h40;

        // Group 2 at half duty with blink.
        run_to(600);
        wr(1'b1, 1'b1, 2'b10, 16'h0480);
        run_to(768);
        e_d2 = 8'h80; e_bl = 3'b100;

        // Write landing on the wrap edge (posedge 1280) waits one more period.
        run_to(1279);
        wr(1'b1, 1'b1, 2'b00, 16'h20FF);
        run_to(1536);
        e_d0 = 8'hFF; e_d1 = 8'h20;

        run_to(1700);
        led_in = 24'h5A3C0F;
        run_to(2100);

        // Asynchronous reset mid-period.
        #2;
        dimrst = 1'b1;
        #1;
        chk("midrst_led_pin", led_pin, 24'h000000);
        chk("midrst_pwm_wrap", {23'd0, pwm_wrap}, 24'h000000);
        for (int i = 0; i < 3; i++) begin
            @(negedge dim_clk);
            chk("hold_led_pin", led_pin, 24'h000000);
        end
        dimrst = 1'b0;
        k = 0;
        e_d0 = 8'hFF; e_d1 = 8'hFF; e_d2 = 8'hFF; e_bl = 3'b000;
        run_to(520);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
